// File: rtl/ccw_usb_src.sv
// ccw_usb_src: frames USB command bytes into CCW packets, buffers two of
// them ping-pong and streams them byte by byte to the HSI master.
module ccw_usb_src #(
    parameter int MAX_LEN    = 16,
    parameter int MAX_REPEAT = 3
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_rx_d,
    input  logic       i_rx_d_vld,
    output logic       o_rx_full,
    output logic       o_rx_ovf,
    output logic       o_err_len,
    output logic       o_err_drop,
    input  logic       i_ccw_tx_rdy,
    output logic       o_ccw_tx_en,
    output logic [7:0] o_ccw_d,
    output logic       o_ccw_d_rdy,
    input  logic       i_ccw_d_sending,
    input  logic       i_ccw_accepted,
    input  logic       i_ccw_repeat_req
);

    localparam int         AW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] LMAX = 8'(MAX_LEN);
    localparam logic [3:0] RMAX = 4'(MAX_REPEAT);

    typedef enum logic [1:0] {W_LEN, W_DATA, W_SKIP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_ARM, R_SEND, R_WAIT_ACK} rstate_t;

    wstate_t r_wstate, w_wstate_n;
    rstate_t r_rstate, w_rstate_n;

    logic [7:0]      r_mem [2][MAX_LEN];
    logic [1:0][7:0] r_len;
    logic [1:0]      r_full, w_full_n;
    logic            r_wp, r_rp;
    logic [7:0]      r_wcnt, r_skip, r_idx;
    logic [3:0]      r_rcnt;
    logic [7:0]      r_d;
    logic            r_drdy;
    logic            r_rx_ovf, r_err_len, r_err_drop;

    logic          w_len_ld, w_skip_ld, w_wr, w_wdone, w_ovf, w_err_len;
    logic          w_load, w_sent, w_adv, w_idx_clr, w_free;
    logic          w_rep_inc, w_rcnt_clr, w_err_drop, w_rx_full;
    logic [7:0]    w_len_wr, w_len_rd, w_rdata;
    logic [AW-1:0] w_waddr, w_raddr;

    assign w_len_wr  = r_len[r_wp];
    assign w_len_rd  = r_len[r_rp];
    assign w_waddr   = r_wcnt[AW-1:0];
    assign w_raddr   = AW'(r_idx - 8'd1);
    assign w_rdata   = (r_idx == 8'd0) ? w_len_rd : r_mem[r_rp][w_raddr];
    // Both slots full only matters at a packet boundary
    assign w_rx_full = (r_wstate == W_LEN) && (&r_full);

    assign o_rx_full   = w_rx_full;
    assign o_rx_ovf    = r_rx_ovf;
    assign o_err_len   = r_err_len;
    assign o_err_drop  = r_err_drop;
    assign o_ccw_tx_en = (r_rstate == R_ARM);
    assign o_ccw_d     = r_d;
    assign o_ccw_d_rdy = r_drdy;

    // Write FSM next state: parse LEN, collect payload or skip bad packet
    always_comb begin
        w_wstate_n = r_wstate;
        w_len_ld   = 1'b0;
        w_skip_ld  = 1'b0;
        w_wr       = 1'b0;
        w_wdone    = 1'b0;
        w_ovf      = 1'b0;
        w_err_len  = 1'b0;
        unique case (r_wstate)
            W_LEN: begin
                if (i_rx_d_vld) begin
                    if (w_rx_full) begin
                        w_ovf = 1'b1;
                    end else if (i_rx_d == 8'd0) begin
                        w_err_len = 1'b1;
                    end else if (i_rx_d > LMAX) begin
                        w_err_len  = 1'b1;
                        w_skip_ld  = 1'b1;
                        w_wstate_n = W_SKIP;
                    end else begin
                        w_len_ld   = 1'b1;
                        w_wstate_n = W_DATA;
                    end
                end
            end
            W_DATA: begin
                if (i_rx_d_vld) begin
                    w_wr = 1'b1;
                    if (r_wcnt + 8'd1 == w_len_wr) begin
                        w_wdone    = 1'b1;
                        w_wstate_n = W_LEN;
                    end
                end
            end
            W_SKIP: begin
                if (i_rx_d_vld && r_skip == 8'd1) begin
                    w_wstate_n = W_LEN;
                end
            end
            default: w_wstate_n = W_LEN;
        endcase
    end

    // Read FSM next state: arm, stream LEN+payload, then await ack/repeat
    always_comb begin
        w_rstate_n = r_rstate;
        w_load     = 1'b0;
        w_sent     = 1'b0;
        w_adv      = 1'b0;
        w_idx_clr  = 1'b0;
        w_free     = 1'b0;
        w_rep_inc  = 1'b0;
        w_rcnt_clr = 1'b0;
        w_err_drop = 1'b0;
        unique case (r_rstate)
            R_IDLE: begin
                if (r_full[r_rp]) begin
                    w_rstate_n = R_ARM;
                end
            end
            R_ARM: begin
                if (i_ccw_tx_rdy) begin
                    w_idx_clr  = 1'b1;
                    w_rstate_n = R_SEND;
                end
            end
            R_SEND: begin
                if (!r_drdy) begin
                    w_load = 1'b1;
                end else if (i_ccw_d_sending) begin
                    w_sent = 1'b1;
                    if (r_idx == w_len_rd) begin
                        w_rstate_n = R_WAIT_ACK;
                    end else begin
                        w_adv = 1'b1;
                    end
                end
            end
            R_WAIT_ACK: begin
                if (i_ccw_accepted) begin
                    w_free     = 1'b1;
                    w_rcnt_clr = 1'b1;
                    w_rstate_n = R_IDLE;
                end else if (i_ccw_repeat_req) begin
                    if (r_rcnt < RMAX) begin
                        w_rep_inc  = 1'b1;
                        w_rstate_n = R_ARM;
                    end else begin
                        w_err_drop = 1'b1;
                        w_free     = 1'b1;
                        w_rcnt_clr = 1'b1;
                        w_rstate_n = R_IDLE;
                    end
                end
            end
            default: w_rstate_n = R_IDLE;
        endcase
    end

    // Slot flags: fill and free may hit different slots in one cycle
    always_comb begin
        w_full_n = r_full;
        if (w_wdone) w_full_n[r_wp] = 1'b1;
        if (w_free)  w_full_n[r_rp] = 1'b0;
    end

    // State registers for both FSMs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wstate <= W_LEN;
            r_rstate <= R_IDLE;
        end else begin
            r_wstate <= w_wstate_n;
            r_rstate <= w_rstate_n;
        end
    end

    // Writer datapath: length, payload counter, skip counter, write pointer
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_len  <= '0;
            r_wcnt <= 8'd0;
            r_skip <= 8'd0;
            r_wp   <= 1'b0;
            r_full <= 2'b00;
        end else begin
            r_full <= w_full_n;
            if (w_len_ld) begin
                r_len[r_wp] <= i_rx_d;
                r_wcnt      <= 8'd0;
            end else if (w_wr) begin
                r_wcnt <= r_wcnt + 8'd1;
            end
            if (w_skip_ld) begin
                r_skip <= i_rx_d;
            end else if (r_wstate == W_SKIP && i_rx_d_vld) begin
                r_skip <= r_skip - 8'd1;
            end
            if (w_wdone) r_wp <= ~r_wp;
        end
    end

    // Payload storage, no reset needed
    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wp][w_waddr] <= i_rx_d;
    end

    // Reader datapath: byte index, output byte, valid, retries, pulses
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_idx      <= 8'd0;
            r_d        <= 8'd0;
            r_drdy     <= 1'b0;
            r_rp       <= 1'b0;
            r_rcnt     <= 4'd0;
            r_rx_ovf   <= 1'b0;
            r_err_len  <= 1'b0;
            r_err_drop <= 1'b0;
        end else begin
            if (w_idx_clr) begin
                r_idx <= 8'd0;
            end else if (w_adv) begin
                r_idx <= r_idx + 8'd1;
            end
            if (w_load) begin
                r_d    <= w_rdata;
                r_drdy <= 1'b1;
            end else if (w_sent) begin
                r_drdy <= 1'b0;
            end
            if (w_rcnt_clr) begin
                r_rcnt <= 4'd0;
            end else if (w_rep_inc) begin
                r_rcnt <= r_rcnt + 4'd1;
            end
            if (w_free) r_rp <= ~r_rp;
            r_rx_ovf   <= w_ovf;
            r_err_len  <= w_err_len;
            r_err_drop <= w_err_drop;
        end
    end

endmodule

// File: tb/tb_ccw_usb_src.sv
// tb_ccw_usb_src: directed vectors for the USB CCW packet source.
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
module tb_ccw_usb_src;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_d = 8'd0;
    logic       rx_d_vld = 1'b0;
    logic       rx_full, rx_ovf, err_len, err_drop;
    logic       tx_rdy = 1'b0;
    logic       tx_en;
    logic [7:0] ccw_d;
    logic       d_rdy;
    logic       d_sending = 1'b0;
    logic       accepted = 1'b0;
    logic       repeat_req = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    ccw_usb_src #(.MAX_LEN(16), .MAX_REPEAT(3)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_rx_d           (rx_d),
        .i_rx_d_vld       (rx_d_vld),
        .o_rx_full        (rx_full),
        .o_rx_ovf         (rx_ovf),
        .o_err_len        (err_len),
        .o_err_drop       (err_drop),
        .i_ccw_tx_rdy     (tx_rdy),
        .o_ccw_tx_en      (tx_en),
        .o_ccw_d          (ccw_d),
        .o_ccw_d_rdy      (d_rdy),
        .i_ccw_d_sending  (d_sending),
        .i_ccw_accepted   (accepted),
        .i_ccw_repeat_req (repeat_req)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic [7:0] b);
        rx_d     = b;
        rx_d_vld = 1'b1;
        tick;
        rx_d_vld = 1'b0;
    endtask

    task automatic recv(input logic [7:0] exp, input string tag);
        int n = 0;
        while (d_rdy !== 1'b1 && n < 16) begin
            tick;
            n++;
        end
        check({tag, "_rdy"}, {7'd0, d_rdy}, 8'd1);
        check(tag, ccw_d, exp);
        d_sending = 1'b1;
        tick;
        d_sending = 1'b0;
        check({tag, "_drop"}, {7'd0, d_rdy}, 8'd0);
    endtask

    task automatic ack;
        accepted = 1'b1;
        tick;
        accepted = 1'b0;
    endtask

    task automatic rep;
        repeat_req = 1'b1;
        tick;
        repeat_req = 1'b0;
    endtask

    initial begin
        tick;
        tick;
        check("rst_tx_en", {7'd0, tx_en}, 8'd0);
        check("rst_d_rdy", {7'd0, d_rdy}, 8'd0);
        check("rst_d", ccw_d, 8'h00);
        check("rst_full", {7'd0, rx_full}, 8'd0);
        check("rst_errs", {5'd0, rx_ovf, err_len, err_drop}, 8'd0);
        rst = 1'b0;
        tick;

        // single packet
        tx_rdy = 1'b1;
        strobe(8'h03);
        strobe(8'hA1);
        strobe(8'hB2);
        strobe(8'hC3);
        check("t1_en_c1", {7'd0, tx_en}, 8'd0);
        tick;
        check("t1_en_c2", {7'd0, tx_en}, 8'd1);
        tick;
        check("t1_en_off", {7'd0, tx_en}, 8'd0);
        check("t1_rd_lat", {7'd0, d_rdy}, 8'd0);
        recv(8'h03, "t1_b0");
        tick;
        check("t1_gap1", {7'd0, d_rdy}, 8'd1);
        recv(8'hA1, "t1_b1");
        recv(8'hB2, "t1_b2");
        recv(8'hC3, "t1_b3");
        tick;
        check("t1_wait", {7'd0, d_rdy}, 8'd0);
        check("t1_hold", ccw_d, 8'hC3);
        ack;
        tick;
        tick;
        check("t1_idle", {7'd0, tx_en}, 8'd0);

        // ping-pong fill and overflow
        tx_rdy = 1'b0;
        strobe(8'h02);
        strobe(8'h11);
        strobe(8'h22);
        check("t2_full_a", {7'd0, rx_full}, 8'd0);
        strobe(8'h02);
        check("t2_full_mid", {7'd0, rx_full}, 8'd0);
        strobe(8'h33);
        strobe(8'h44);
        check("t2_full_b", {7'd0, rx_full}, 8'd1);
        check("t2_tx_en", {7'd0, tx_en}, 8'd1);
        strobe(8'h02);
        check("t2_ovf", {7'd0, rx_ovf}, 8'd1);
        tick;
        check("t2_ovf_end", {7'd0, rx_ovf}, 8'd0);
        check("t2_full_hold", {7'd0, rx_full}, 8'd1);
        tx_rdy = 1'b1;
        recv(8'h02, "t2_a0");
        recv(8'h11, "t2_a1");
        recv(8'h22, "t2_a2");
        ack;
        check("t2_full_clr", {7'd0, rx_full}, 8'd0);
        recv(8'h02, "t2_b0");
        recv(8'h33, "t2_b1");
        recv(8'h44, "t2_b2");
        ack;

        // repeat requests up to the limit, then drop
        strobe(8'h01);
        strobe(8'h55);
        for (int r = 0; r < 4; r++) begin
            recv(8'h01, $sformatf("t3_len_%0d", r));
            recv(8'h55, $sformatf("t3_dat_%0d", r));
            check($sformatf("t3_nodrop_%0d", r), {7'd0, err_drop}, 8'd0);
            if (r < 3) begin
                rep;
                check($sformatf("t3_rearm_%0d", r), {7'd0, tx_en}, 8'd1);
            end
        end
        rep;
        check("t3_drop", {7'd0, err_drop}, 8'd1);
        tick;
        check("t3_drop_end", {7'd0, err_drop}, 8'd0);
        check("t3_freed", {7'd0, tx_en}, 8'd0);

        // bad length bytes
        strobe(8'h00);
        check("t4_len0", {7'd0, err_len}, 8'd1);
        tick;
        check("t4_len0_end", {7'd0, err_len}, 8'd0);
        strobe(8'h20);
        check("t4_len32", {7'd0, err_len}, 8'd1);
        for (int i = 0; i < 32; i++) begin
            strobe(8'(i));
        end
        check("t4_skip_err", {7'd0, err_len}, 8'd0);
        tick;
        check("t4_skip_en", {7'd0, tx_en}, 8'd0);
        strobe(8'h01);
        strobe(8'h7E);
        recv(8'h01, "t4_b0");
        recv(8'h7E, "t4_b1");
        ack;

        // reset during transmission
        strobe(8'h03);
        strobe(8'h10);
        strobe(8'h20);
        strobe(8'h30);
        recv(8'h03, "t5_b0");
        tick;
        check("t5_idx1", ccw_d, 8'h10);
        rst = 1'b1;
        #1;
        check("t5_rst_en", {7'd0, tx_en}, 8'd0);
        check("t5_rst_rdy", {7'd0, d_rdy}, 8'd0);
        check("t5_rst_d", ccw_d, 8'h00);
        check("t5_rst_flags", {4'd0, rx_full, rx_ovf, err_len, err_drop},
              8'd0);
        tick;
        rst = 1'b0;
        tick;
        tick;
        tick;
        check("t5_post_en", {7'd0, tx_en}, 8'd0);
        strobe(8'h01);
        strobe(8'h99);
        check("t5_new_c1", {7'd0, tx_en}, 8'd0);
        tick;
        check("t5_new_c2", {7'd0, tx_en}, 8'd1);
        recv(8'h01, "t5_n0");
        recv(8'h99, "t5_n1");
        ack;

        // accept and repeat together: accept wins
        strobe(8'h02);
        strobe(8'hAB);
        strobe(8'hCD);
        recv(8'h02, "t6_b0");
        recv(8'hAB, "t6_b1");
        recv(8'hCD, "t6_b2");
        accepted   = 1'b1;
        repeat_req = 1'b1;
        tick;
        accepted   = 1'b0;
        repeat_req = 1'b0;
        check("t6_nodrop", {7'd0, err_drop}, 8'd0);
        check("t6_no_rearm", {7'd0, tx_en}, 8'd0);
        tick;
        tick;
        check("t6_idle_en", {7'd0, tx_en}, 8'd0);
        check("t6_idle_rdy", {7'd0, d_rdy}, 8'd0);
        strobe(8'h01);
        strobe(8'h5A);
        recv(8'h01, "t6_n0");
        recv(8'h5A, "t6_n1");
        ack;

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
